// File: rtl/cpu_paddle_ctrl.sv
// Computer-opponent paddle controller: rests at a home position, tracks the ball after a reaction delay.
// Optional aiming error (random target offset from an LFSR) is enabled by defining CPU_PADDLE_ERR_EN.
module cpu_paddle_ctrl #(
  parameter int PADDLE_HEIGHT = 70,
  parameter int SCREEN_HEIGHT = 480,
  parameter int Y_HOME        = 205,
  parameter int DEADZONE      = 4,
  parameter int REACT_CYCLES  = 8,
  parameter int STEP_DIV      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] ball_y,
  input  logic       ball_toward,
  input  logic [8:0] paddle_y,
  output logic       move_up,
  output logic       move_down,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, HOME, WAIT, TRACK} state_t;

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int WW = (REACT_CYCLES > 1) ? $clog2(REACT_CYCLES) : 1;

  localparam logic [SW-1:0]      STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [WW-1:0]      WAIT_LAST = WW'(REACT_CYCLES - 1);
  localparam logic signed [9:0]  HALF_H    = 10'(PADDLE_HEIGHT / 2);
  localparam logic signed [9:0]  Y_MAX     = 10'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic signed [9:0]  HOME_Y    = 10'(Y_HOME);
  localparam logic signed [9:0]  DZ        = 10'(DEADZONE);

  state_t            state;
  state_t            state_next;
  logic [WW-1:0]     wait_cnt;
  logic [SW-1:0]     step_cnt;
  logic signed [9:0] offset;
  logic signed [9:0] raw_track;
  logic signed [9:0] track_target;
  logic signed [9:0] target;
  logic signed [9:0] err;
  logic              active;
  logic              tick;
  logic              want_up;
  logic              want_down;

`ifdef CPU_PADDLE_ERR_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
`else
  assign offset = '0;
`endif

  always_comb begin
    state_next = state;
    if (!start) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  state_next = HOME;
        HOME:  if (ball_toward) state_next = (REACT_CYCLES == 0) ? TRACK : WAIT;
        WAIT: begin
          if (!ball_toward)               state_next = HOME;
          else if (wait_cnt == WAIT_LAST) state_next = TRACK;
        end
        TRACK: if (!ball_toward) state_next = HOME;
        default: state_next = IDLE;
      endcase
    end
  end

  // Clamping the track target keeps every commanded move inside the paddle's legal range.
  always_comb begin
    raw_track = signed'({1'b0, ball_y}) - HALF_H + offset;
    if (raw_track < 10'sd0)      track_target = '0;
    else if (raw_track > Y_MAX)  track_target = Y_MAX;
    else                         track_target = raw_track;
    target    = (state == TRACK) ? track_target : HOME_Y;
    err       = target - signed'({1'b0, paddle_y});
    active    = (state == HOME) || (state == TRACK);
    tick      = active && (step_cnt == STEP_LAST);
    want_down = tick && (err > DZ);
    want_up   = tick && (err < -DZ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      step_cnt  <= '0;
      move_up   <= 1'b0;
      move_down <= 1'b0;
      busy      <= 1'b0;
`ifdef CPU_PADDLE_ERR_EN
      lfsr      <= 8'hA5;
      offset    <= '0;
`endif
    end else begin
      state     <= state_next;
      move_up   <= want_up && start;
      move_down <= want_down && start;
      busy      <= (state_next == TRACK);

      // The step divider restarts whenever HOME or TRACK is (re)entered.
      if (active && (state_next == state))
        step_cnt <= tick ? '0 : step_cnt + SW'(1);
      else
        step_cnt <= '0;

      if ((state == WAIT) && (state_next == WAIT))
        wait_cnt <= wait_cnt + WW'(1);
      else
        wait_cnt <= '0;

`ifdef CPU_PADDLE_ERR_EN
      lfsr <= {lfsr[6:0], lfsr_fb};
      if ((state_next == TRACK) && (state != TRACK))
        offset <= {{5{lfsr[4]}}, lfsr[4:0]};
`endif
    end
  end

endmodule

// File: tb/tb_cpu_paddle_ctrl.sv
// Directed self-checking bench for cpu_paddle_ctrl with small screen parameters.
module tb_cpu_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] ball_y;
  logic       ball_toward;
  logic [8:0] paddle_y;
  logic       move_up;
  logic       move_down;
  logic       busy;

  int assert_count = 0;
  int fail_count   = 0;

  cpu_paddle_ctrl #(
    .PADDLE_HEIGHT(10),
    .SCREEN_HEIGHT(50),
    .Y_HOME(20),
    .DEADZONE(1),
    .REACT_CYCLES(3),
    .STEP_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ball_y(ball_y),
    .ball_toward(ball_toward),
    .paddle_y(paddle_y),
    .move_up(move_up),
    .move_down(move_down),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic bt, input logic [8:0] by, input logic [8:0] py);
    start       = s;
    ball_toward = bt;
    ball_y      = by;
    paddle_y    = py;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input int exp_up, input int exp_down, input int exp_busy);
    checkOutput({tag, " move_up"}, 32'(move_up), exp_up);
    checkOutput({tag, " move_down"}, 32'(move_down), exp_down);
    checkOutput({tag, " busy"}, 32'(busy), exp_busy);
  endtask

  // Counts pulses over a window; with STEP_DIV=2 a steady request gives n/2 pulses.
  task automatic checkWindow(input string tag, input int n, input int exp_up, input int exp_down,
                             input logic exp_busy);
    int ups = 0;
    int downs = 0;
    int both = 0;
    int busy_bad = 0;
    repeat (n) begin
      nextCycle();
      ups   += int'(move_up);
      downs += int'(move_down);
      if (move_up && move_down) both++;
      if (busy !== exp_busy) busy_bad++;
    end
    checkOutput({tag, " up_count"}, 32'(ups), exp_up);
    checkOutput({tag, " down_count"}, 32'(downs), exp_down);
    checkOutput({tag, " both_high"}, 32'(both), 0);
    checkOutput({tag, " busy_wrong"}, 32'(busy_bad), 0);
  endtask

  initial begin
    // 1: reset, then start low holds everything quiet
    applyStimulus(1'b0, 1'b1, 9'd45, 9'd0);
    reset = 1'b1;
    nextCycle();
    nextCycle();
    checkAll("reset", 0, 0, 0);
    reset = 1'b0;
    checkWindow("idle", 10, 0, 0, 1'b0);

    // 2: HOME behaviour around the dead zone (target 20)
    applyStimulus(1'b1, 1'b0, 9'd45, 9'd30);
    nextCycle();
    nextCycle();
    checkWindow("home_py30", 8, 4, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 9'd45, 9'd21);
    nextCycle();
    checkWindow("home_py21", 8, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 9'd45, 9'd19);
    nextCycle();
    checkWindow("home_py19", 8, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 9'd45, 9'd18);
    nextCycle();
    checkWindow("home_py18", 8, 0, 4, 1'b0);

    // 3: reaction delay, then tracking to clamped target 40
    applyStimulus(1'b1, 1'b0, 9'd45, 9'd20);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 9'd45, 9'd20);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkAll($sformatf("wait%0d", i), 0, 0, 0);
    end
    nextCycle();
    checkAll("track_entry", 0, 0, 1);
    nextCycle();
    checkOutput("track_e1 move_down", 32'(move_down), 0);
    nextCycle();
    checkOutput("track_e2 move_down", 32'(move_down), 1);
    nextCycle();
    checkOutput("track_e3 move_down", 32'(move_down), 0);
    nextCycle();
    checkOutput("track_e4 move_down", 32'(move_down), 1);
    checkWindow("track_down", 8, 0, 4, 1'b1);
    applyStimulus(1'b1, 1'b1, 9'd45, 9'd39);
    nextCycle();
    checkWindow("track_py39", 8, 0, 0, 1'b1);

    // 4: lower clamp at 0
    applyStimulus(1'b1, 1'b1, 9'd2, 9'd0);
    nextCycle();
    checkWindow("track_py0", 8, 0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 9'd2, 9'd5);
    nextCycle();
    checkWindow("track_py5", 8, 4, 0, 1'b1);

    // 5: aborted wait returns HOME and restarts the full delay
    applyStimulus(1'b1, 1'b0, 9'd2, 9'd20);
    nextCycle();
    checkOutput("track_exit busy", 32'(busy), 0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 9'd45, 9'd20);
    nextCycle();
    checkAll("abort_w0", 0, 0, 0);
    nextCycle();
    checkAll("abort_w1", 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 9'd45, 9'd20);
    nextCycle();
    checkAll("abort_home", 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 9'd45, 9'd20);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkAll($sformatf("rewait%0d", i), 0, 0, 0);
    end
    nextCycle();
    checkOutput("retrack busy", 32'(busy), 1);

    // 6: start drop and reset during an active pulse
    for (int i = 0; i < 10; i++) begin
      if (move_down) break;
      nextCycle();
    end
    checkOutput("pulse_before_stop move_down", 32'(move_down), 1);
    applyStimulus(1'b0, 1'b1, 9'd45, 9'd20);
    nextCycle();
    checkAll("stop", 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 9'd45, 9'd20);
    for (int i = 0; i < 20; i++) begin
      if (busy && move_down) break;
      nextCycle();
    end
    checkOutput("pulse_before_reset move_down", 32'(move_down), 1);
    reset = 1'b1;
    nextCycle();
    checkAll("reset_mid", 0, 0, 0);
    nextCycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) nextCycle();
    checkOutput("post_reset_wait busy", 32'(busy), 0);
    nextCycle();
    checkOutput("post_reset_track busy", 32'(busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/cpu_paddle_ctrl.md
Name: cpu_paddle_ctrl

Overview:
Computer-opponent controller that drives the move_up/move_down command inputs of one paddle instance. It reads the ball position and direction plus the paddle's y_min feedback, then issues rate-limited move commands. The paddle rests at a home position and tracks the ball after a programmable reaction delay. It sits between the ball module and the CPU-side paddle.

Parameters:
PADDLE_HEIGHT, 70, paddle height in pixels; must match the paddle instance
SCREEN_HEIGHT, 480, screen height in pixels
Y_HOME, 205, home y_min used while the ball moves away
DEADZONE, 4, tolerance in pixels; no move while |target - paddle_y| <= DEADZONE
REACT_CYCLES, 8, number of cycles the block ignores the ball after it turns toward this paddle
STEP_DIV, 2, a move is evaluated once every STEP_DIV cycles (1 = every cycle)

Ports:
clk  input  1  master clock
reset  input  1  synchronous, active-high reset
start  input  1  enables the controller; when low, the block is forced to IDLE
ball_y  input  9  ball y coordinate
ball_toward  input  1  high while the ball travels toward this paddle
paddle_y  input  9  current paddle y_min (feedback)
move_up  output  1  decrease paddle y
move_down  output  1  increase paddle y
busy  output  1  high when state is TRACK

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: state=IDLE, wait counter=0, step counter=0; move_up=0, move_down=0, busy=0. Reset has priority over every other input.
- States and transitions (all evaluated on the clk edge):
  - IDLE -> HOME when start=1.
  - HOME -> WAIT when ball_toward=1. If REACT_CYCLES=0, HOME goes directly to TRACK.
  - WAIT -> TRACK after REACT_CYCLES consecutive cycles in WAIT with ball_toward=1.
  - WAIT -> HOME if ball_toward=0. The wait counter clears.
  - TRACK -> HOME when ball_toward=0.
  - Any state -> IDLE when start=0. Outputs are 0 on the next cycle.
- Target computation, using 10-bit signed arithmetic:
  - HOME: target = Y_HOME.
  - TRACK: target = ball_y - PADDLE_HEIGHT/2 (integer division), clamped to [0, SCREEN_HEIGHT-PADDLE_HEIGHT].
  - IDLE and WAIT: no target; no moves are issued.
- Step tick:
  - The step counter runs 0..STEP_DIV-1 in HOME and TRACK only. It clears on entry to those states and in every other state.
  - A tick occurs when the counter equals STEP_DIV-1.
- Move decision at a tick: err = target - paddle_y, signed 10-bit.
  - err > DEADZONE: move_down=1.
  - err < -DEADZONE: move_up=1.
  - Otherwise both outputs stay 0.
- Outputs are registered: a 1-cycle pulse appears in the cycle after the tick edge. Both outputs are 0 on non-tick cycles.
- move_up and move_down are never high together.
- The block never commands motion past the screen edges. Clamping guarantees that target lies within the paddle's legal range.
- busy is a registered copy of state==TRACK.
- Reset or start=0 mid-pulse clears the outputs on the next edge. No pending move is retained.

Optional Feature:
CPU_PADDLE_ERR_EN
- With the macro defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; loaded with 8'hA5 on reset) advances every cycle.
  - On each WAIT->TRACK (or HOME->TRACK) transition, offset = sign-extended lfsr[4:0] (range -16..+15) is latched.
  - The offset is added to the TRACK target before clamping, so the CPU opponent can miss.
  - The offset is held until the next entry into TRACK.
- Without the macro: offset is constant 0, there is no LFSR logic, and behaviour is exactly as described above.

Test Plan:
Bench parameters: PADDLE_HEIGHT=10, SCREEN_HEIGHT=50, Y_HOME=20, DEADZONE=1, REACT_CYCLES=3, STEP_DIV=2; macro undefined.
1. Pulse reset, then hold start=0, ball_toward=1, ball_y=45 for 10 cycles -> move_up=move_down=0 and busy=0 throughout.
2. Set start=1, ball_toward=0, paddle_y=30 -> move_up pulses every 2nd cycle, move_down=0. Set paddle_y=21, then 19 -> no pulses at either value. Set paddle_y=18 -> move_down pulses.
3. With paddle_y=20, raise ball_toward=1 with ball_y=45 -> no moves during 3 WAIT cycles. Then busy=1 and move_down pulses every 2nd cycle (target clamps to 40). Set paddle_y=39 -> pulses stop.
4. In TRACK, set ball_y=2 (target clamps to 0) and paddle_y=0 -> no move_up. Set paddle_y=5 -> move_up pulses.
5. Raise ball_toward, then drop it after 2 WAIT cycles -> return to HOME with no TRACK moves. Re-raise ball_toward -> a full 3-cycle delay again before busy=1.
6. In TRACK during an active pulse:
   - Drop start -> outputs and busy are 0 on the next cycle.
   - Restore start, then assert reset -> state is IDLE and outputs are 0 the following cycle.
